// File: rtl/disp_frame_seq.sv
// Display-driver feeder: runs the LCD init sequence once, then streams HOME + frame words for the BCD time.
// Optional blink of the digits while editing is enabled by defining DISP_FRAME_SEQ_BLINK_EN.
module disp_frame_seq #(
   parameter int SIZE        = 4,
   parameter int INIT_DELAY  = 16,
   parameter int REFRESH_DIV = 1000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_hours,
   input  logic [7:0]        i_minutes,
   input  logic              i_edit,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [10:0]       o_comm,
   output logic [SIZE*8-1:0] o_data
);

   localparam int WAIT_W = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
   localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_DELAY - 1);
   localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

   localparam logic [2:0] S_WAIT  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_IDLE  = 3'd2;
   localparam logic [2:0] S_HOME  = 3'd3;
   localparam logic [2:0] S_FRAME = 3'd4;

   localparam logic [10:0] CMD_HOME  = 11'h080;
   localparam logic [10:0] CMD_FRAME = 11'h200;

   logic [2:0]        state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [REF_W-1:0]  ref_cnt;
   logic [1:0]        init_idx;
   logic [15:0]       snap;
   logic [15:0]       time_now;
   logic              xfer;
   logic              expire;
   logic              changed;
   logic              refresh;
   logic              blank_next;

   function automatic logic [7:0] init_instr(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   function automatic logic [7:0] digit_char(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h2D;
   endfunction

   // Only the low four bytes carry digits; everything else stays a space.
   function automatic logic [SIZE*8-1:0] build_frame(input logic [15:0] t, input logic blank);
      logic [SIZE*8-1:0] f;
      f = {SIZE{8'h20}};
      if (!blank) begin
         for (int i = 0; i < 4; i++) begin
            if (i < SIZE) f[8*i +: 8] = digit_char(t[4*i +: 4]);
         end
      end
      return f;
   endfunction

   assign time_now = {i_hours, i_minutes};
   assign xfer     = o_valid && i_ready;
   assign expire   = (ref_cnt == REF_LAST);
   assign changed  = (time_now != snap);
   assign refresh  = (state == S_IDLE) && (expire || changed);

`ifdef DISP_FRAME_SEQ_BLINK_EN
   logic phase;
   logic phase_next;

   // Phase advances only on periodic expiry, and is forced low outside edit mode.
   always_comb begin
      phase_next = phase;
      if (!i_edit)
         phase_next = 1'b0;
      else if ((state == S_IDLE) && expire)
         phase_next = ~phase;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) phase <= 1'b0;
      else       phase <= phase_next;
   end

   assign blank_next = i_edit && phase_next;
`else
   logic unused_edit;
   assign unused_edit = i_edit;
   assign blank_next  = 1'b0;
`endif

   // Outputs are registered and reloaded on the transfer edge, so i_ready never reaches o_valid combinationally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= S_WAIT;
         wait_cnt <= '0;
         ref_cnt  <= '0;
         init_idx <= 2'd0;
         snap     <= 16'h0000;
         o_valid  <= 1'b0;
         o_comm   <= 11'h000;
         o_data   <= {SIZE{8'h20}};
      end else begin
         case (state)
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state    <= S_INIT;
                  wait_cnt <= '0;
                  init_idx <= 2'd0;
                  o_valid  <= 1'b1;
                  o_comm   <= {3'b000, init_instr(2'd0)};
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_INIT: begin
               if (xfer) begin
                  if (init_idx == 2'd3) begin
                     state  <= S_HOME;
                     o_comm <= CMD_HOME;
                     snap   <= time_now;
                     o_data <= build_frame(time_now, blank_next);
                  end else begin
                     init_idx <= init_idx + 2'd1;
                     o_comm   <= {3'b000, init_instr(init_idx + 2'd1)};
                  end
               end
            end
            S_IDLE: begin
               ref_cnt <= expire ? '0 : ref_cnt + 1'b1;
               if (refresh) begin
                  state   <= S_HOME;
                  o_valid <= 1'b1;
                  o_comm  <= CMD_HOME;
                  snap    <= time_now;
                  o_data  <= build_frame(time_now, blank_next);
               end
            end
            S_HOME: begin
               if (xfer) begin
                  state  <= S_FRAME;
                  o_comm <= CMD_FRAME;
               end
            end
            S_FRAME: begin
               if (xfer) begin
                  state   <= S_IDLE;
                  o_valid <= 1'b0;
                  ref_cnt <= '0;
               end
            end
            default: begin
               state   <= S_WAIT;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_disp_frame_seq.sv
// Scoreboard bench for disp_frame_seq: stimulus pushes expected words, a negedge monitor pops and compares.
// Blink expectations are modelled when DISP_FRAME_SEQ_BLINK_EN is defined.
module tb_disp_frame_seq;

   localparam int SIZE        = 4;
   localparam int INIT_DELAY  = 16;
   localparam int REFRESH_DIV = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  hours = 8'h12;
   logic [7:0]  minutes = 8'h34;
   logic        edit = 1'b0;
   logic        ready = 1'b1;
   logic        o_valid;
   logic [10:0] o_comm;
   logic [31:0] o_data;

   typedef struct {
      logic [10:0] comm;
      logic [31:0] data;
      bit          chk;
      int          gap;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   int checks = 0;
   int errors = 0;
   int frames_seen = 0;
   int frames_expected = 0;
   int gap_cnt = 0;
   int ready_mode = 2;
   int stall_left = 5;
   bit stall_pend = 0;
   logic [10:0] stall_comm;
   logic [31:0] stall_data;

   logic [7:0] cur_h = 8'h12;
   logic [7:0] cur_m = 8'h34;
   bit         cur_e = 0;
   bit         phase = 0;

   disp_frame_seq #(
      .SIZE(SIZE), .INIT_DELAY(INIT_DELAY), .REFRESH_DIV(REFRESH_DIV)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_hours(hours), .i_minutes(minutes), .i_edit(edit),
      .i_ready(ready), .o_valid(o_valid), .o_comm(o_comm), .o_data(o_data)
   );

   always #5 clk = ~clk;

   initial begin
      repeat (60000) @(posedge clk);
      $display("[TB] FAIL watchdog: run exceeded cycle budget, frames seen %0d required %0d", frames_seen, frames_expected);
      checks++;
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Ready driver: 0 always ready, 1 random, 2 stall five cycles on 0x00C, 4 refuse frame words.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: ready = 1'b1;
         1: ready = ($urandom_range(0, 3) != 0);
         2: begin
            if (o_valid && o_comm == 11'h00C && stall_left > 0) begin
               ready = 1'b0;
               stall_left--;
            end else begin
               ready = 1'b1;
            end
         end
         default: ready = !(o_valid && o_comm == 11'h200);
      endcase
   end

   always @(negedge clk) begin
      if (rst) begin
         gap_cnt    = 0;
         stall_pend = 0;
      end else begin
         if (stall_pend) begin
            checks++;
            if (!(o_valid && o_comm == stall_comm && o_data == stall_data)) begin
               errors++;
               $display("[TB] FAIL hold_stable: valid=%0b comm=%h data=%h, required valid=1 comm=%h data=%h",
                        o_valid, o_comm, o_data, stall_comm, stall_data);
            end
         end
         stall_pend = 0;
         if (o_valid && ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_word: got comm=%h data=%h, required no transfer", o_comm, o_data);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (o_comm != e.comm) begin
                  errors++;
                  $display("[TB] FAIL comm: got %h, required %h", o_comm, e.comm);
               end
               if (e.chk) begin
                  checks++;
                  if (o_data != e.data) begin
                     errors++;
                     $display("[TB] FAIL frame_data: got %h, required %h", o_data, e.data);
                  end
               end
               if (e.gap >= 0) begin
                  checks++;
                  if (gap_cnt != e.gap) begin
                     errors++;
                     $display("[TB] FAIL idle_gap (comm %h): got %0d cycles, required %0d", e.comm, gap_cnt, e.gap);
                  end
               end
            end
            if (o_comm == 11'h200) frames_seen++;
            gap_cnt = 0;
         end else if (o_valid) begin
            stall_pend = 1;
            stall_comm = o_comm;
            stall_data = o_data;
         end else begin
            gap_cnt++;
         end
      end
   end

   function automatic logic [31:0] model_frame(input logic [7:0] h, input logic [7:0] m, input bit blank);
      int v;
      int n;
      logic [31:0] f;
      v = h * 256 + m;
      f = 32'h0;
      for (int i = 0; i < 4; i++) begin
         n = (v / (1 << (4 * i))) % 16;
         if (blank)      f = f | (32'h20 << (8 * i));
         else if (n < 10) f = f | (32'(48 + n) << (8 * i));
         else            f = f | (32'h2D << (8 * i));
      end
      return f;
   endfunction

   task automatic push_word(input logic [10:0] comm, input logic [31:0] data, input bit chk, input int gap);
      exp_t w;
      w.comm = comm;
      w.data = data;
      w.chk  = chk;
      w.gap  = gap;
      exp_q.push_back(w);
   endtask

   task automatic push_refresh(input int gap, input bit is_expiry);
      bit blank;
      blank = 0;
`ifdef DISP_FRAME_SEQ_BLINK_EN
      if (is_expiry) phase = cur_e ? ~phase : 1'b0;
      else if (!cur_e) phase = 1'b0;
      blank = cur_e && phase;
`else
      if (is_expiry) blank = 0;
`endif
      push_word(11'h080, 32'h0, 0, gap);
      push_word(11'h200, model_frame(cur_h, cur_m, blank), 1, 0);
      frames_expected++;
   endtask

   task automatic push_init(input logic [31:0] frame);
      push_word(11'h038, 32'h0, 0, INIT_DELAY);
      push_word(11'h00C, 32'h0, 0, 0);
      push_word(11'h006, 32'h0, 0, 0);
      push_word(11'h001, 32'h0, 0, 0);
      push_word(11'h080, 32'h0, 0, 0);
      push_word(11'h200, frame, 1, 0);
      frames_expected++;
   endtask

   task automatic wait_frames();
      wait (frames_seen >= frames_expected);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [7:0] h, input logic [7:0] m, input bit ed, input int k);
      repeat (k) @(posedge clk);
      #1;
      hours   = h;
      minutes = m;
      edit    = ed;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic logic [7:0] rand_byte();
      if ($urandom_range(0, 1) == 1) return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      return 8'($urandom_range(0, 255));
   endfunction

   task automatic pick_time(output logic [7:0] h, output logic [7:0] m);
      do begin
         h = rand_byte();
         m = rand_byte();
      end while ({h, m} == {cur_h, cur_m});
   endtask

   initial begin
      logic [7:0] nh;
      logic [7:0] nm;
      bit         ne;
      int         k;
      int         sel;

      repeat (3) @(posedge clk);
      #1;
      check_output("reset_valid", 32'(o_valid), 32'h0);
      check_output("reset_comm", 32'(o_comm), 32'h0);
      check_output("reset_data", o_data, 32'h20202020);
      push_init(32'h31323334);
      rst = 1'b0;
      wait_frames();

      $display("[TB] directed minute change and invalid BCD");
      push_word(11'h080, 32'h0, 0, 4);
      push_word(11'h200, 32'h31323335, 1, 0);
      frames_expected++;
      cur_m = 8'h35;
      apply_stimulus(8'h12, 8'h35, 0, 3);
      wait_frames();

      push_word(11'h080, 32'h0, 0, 1);
      push_word(11'h200, 32'h312D3030, 1, 0);
      frames_expected++;
      cur_h = 8'h1F;
      cur_m = 8'h00;
      apply_stimulus(8'h1F, 8'h00, 0, 0);
      wait_frames();

      $display("[TB] randomized refresh traffic");
      ready_mode = 1;
      for (int it = 0; it < 30; it++) begin
         sel = $urandom_range(0, 2);
         if (sel == 0) begin
            push_refresh(REFRESH_DIV, 1);
            wait_frames();
         end else if (sel == 1) begin
            k = $urandom_range(0, REFRESH_DIV - 1);
            pick_time(nh, nm);
            ne = 1'($urandom_range(0, 1));
            cur_h = nh;
            cur_m = nm;
            cur_e = ne;
            push_refresh((k + 1 >= REFRESH_DIV) ? REFRESH_DIV : k + 1, k == REFRESH_DIV - 1);
            apply_stimulus(nh, nm, ne, k);
            wait_frames();
         end else begin
            k = $urandom_range(0, REFRESH_DIV - 1);
            pick_time(nh, nm);
            cur_h = nh;
            cur_m = nm;
            push_refresh((k + 1 >= REFRESH_DIV) ? REFRESH_DIV : k + 1, k == REFRESH_DIV - 1);
            apply_stimulus(nh, nm, cur_e, k);
            pick_time(nh, nm);
            cur_h = nh;
            cur_m = nm;
            push_refresh(1, 0);
            wait (o_valid && o_comm == 11'h080);
            #1;
            hours   = nh;
            minutes = nm;
            wait_frames();
         end
      end

      $display("[TB] reset while a frame word is stalled");
      ready_mode = 4;
      pick_time(nh, nm);
      cur_h = nh;
      cur_m = nm;
      push_word(11'h080, 32'h0, 0, 3);
      apply_stimulus(nh, nm, cur_e, 2);
      wait (o_valid && o_comm == 11'h200);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_output("midreset_valid", 32'(o_valid), 32'h0);
      check_output("midreset_comm", 32'(o_comm), 32'h0);
      rst = 1'b0;
      ready_mode = 1;
      phase = 0;
      push_init(model_frame(cur_h, cur_m, 0));
      wait_frames();

      for (int it = 0; it < 4; it++) begin
         push_refresh(REFRESH_DIV, 1);
         wait_frames();
      end

      repeat (5) @(posedge clk);
      check_output("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
